// File: rtl/pic_pkg.sv
// pic_pkg: shared types, read-select codes and bit positions for the 8259 bus front end.
package pic_pkg;
    localparam int PIC_DW = 8;

    typedef enum logic [2:0] {
        CW_ICW1 = 3'd0,
        CW_ICW2 = 3'd1,
        CW_ICW3 = 3'd2,
        CW_ICW4 = 3'd3,
        CW_OCW1 = 3'd4,
        CW_OCW2 = 3'd5,
        CW_OCW3 = 3'd6,
        CW_NONE = 3'd7
    } cw_type_t;

    typedef enum logic [2:0] {
        WAIT_ICW1,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } seq_state_t;

    localparam logic [2:0] RD_IDLE = 3'b000;
    localparam logic [2:0] RD_IRR  = 3'b001;
    localparam logic [2:0] RD_ISR  = 3'b101;
    localparam logic [2:0] RD_IMR  = 3'b011;

    localparam int ICW1_D4 = 4;
    localparam int IC4     = 0;
    localparam int SNGL    = 1;
    localparam int OCW3_D3 = 3;
    localparam int RR      = 1;
    localparam int RIS     = 0;

    function automatic logic [2:0] rd_code(input logic isr);
        return isr ? RD_ISR : RD_IRR;
    endfunction
endpackage

// File: rtl/pic_bus_sync.sv
// pic_bus_sync: optional input synchronizer (PIC_INPUT_SYNC_EN) plus write capture/commit detect.
// A write commits on the first sample with wr_n high after a clean write sample.
module pic_bus_sync
    import pic_pkg::*;
#(
    parameter int DW = PIC_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs_n,
    input  logic          rd_n,
    input  logic          wr_n,
    input  logic          a0,
    input  logic [DW-1:0] data_in,
    output logic          wr_commit,
    output logic          wr_a0,
    output logic [DW-1:0] wr_data,
    output logic          rd_req,
    output logic          rd_a0
);
    logic [DW+3:0] bus;
    logic          s_cs_n, s_rd_n, s_wr_n, s_a0;
    logic [DW-1:0] s_data;
    logic          wr_cycle, pending;

`ifdef PIC_INPUT_SYNC_EN
    localparam logic [DW+3:0] BUS_IDLE = {3'b111, {(DW+1){1'b0}}};
    logic [DW+3:0] s1, s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= BUS_IDLE;
            s2 <= BUS_IDLE;
        end else begin
            s1 <= {cs_n, rd_n, wr_n, a0, data_in};
            s2 <= s1;
        end
    end

    assign bus = s2;
`else
    assign bus = {cs_n, rd_n, wr_n, a0, data_in};
`endif

    assign {s_cs_n, s_rd_n, s_wr_n, s_a0, s_data} = bus;
    assign wr_cycle = ~s_cs_n & ~s_wr_n & s_rd_n;

    // Any sample that is not a clean write either commits (wr_n high) or discards the capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            wr_a0   <= 1'b0;
            wr_data <= '0;
        end else begin
            pending <= wr_cycle;
            if (wr_cycle) begin
                wr_a0   <= s_a0;
                wr_data <= s_data;
            end
        end
    end

    assign wr_commit = pending & s_wr_n;
    assign rd_req    = ~s_cs_n & ~s_rd_n & s_wr_n;
    assign rd_a0     = s_a0;
endmodule

// File: rtl/pic_rw_sequencer.sv
// pic_rw_sequencer: 8259 bus front end; ICW1..ICW4 init sequencing, command classification, read select.
// Define PIC_INPUT_SYNC_EN to add a 2-flop input synchronizer (+2 cycles latency).
module pic_rw_sequencer
    import pic_pkg::*;
#(
    parameter int DW         = PIC_DW,
    parameter bit RD_DEFAULT = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs_n,
    input  logic          rd_n,
    input  logic          wr_n,
    input  logic          a0,
    input  logic [DW-1:0] data_in,
    output logic          cw_valid,
    output logic [2:0]    cw_type,
    output logic [DW-1:0] cw_data,
    output logic [2:0]    read_sel,
    output logic          data_oe,
    output logic          init_done
);
    localparam logic RD_ISR_RST = (RD_DEFAULT == 1'b0);

    seq_state_t    state, state_n;
    logic          wr_commit, wr_a0, rd_req, rd_a0;
    logic [DW-1:0] wr_data;
    logic          rd_isr, rd_isr_n, sngl, sngl_n, ic4, ic4_n, emit;
    logic [2:0]    typ_n, read_sel_n;

    pic_bus_sync #(.DW(DW)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .cs_n      (cs_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .a0        (a0),
        .data_in   (data_in),
        .wr_commit (wr_commit),
        .wr_a0     (wr_a0),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_a0     (rd_a0)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WAIT_ICW1;
            rd_isr   <= RD_ISR_RST;
            sngl     <= 1'b0;
            ic4      <= 1'b0;
            cw_valid <= 1'b0;
            cw_type  <= CW_NONE;
            cw_data  <= '0;
            read_sel <= RD_IDLE;
            data_oe  <= 1'b0;
        end else begin
            state    <= state_n;
            rd_isr   <= rd_isr_n;
            sngl     <= sngl_n;
            ic4      <= ic4_n;
            cw_valid <= emit;
            if (emit) begin
                cw_type <= typ_n;
                cw_data <= wr_data;
            end
            read_sel <= read_sel_n;
            data_oe  <= rd_req;
        end
    end

    // ICW1 restarts the sequence from any state; everything else depends on where we are.
    always_comb begin
        state_n  = state;
        rd_isr_n = rd_isr;
        sngl_n   = sngl;
        ic4_n    = ic4;
        emit     = 1'b0;
        typ_n    = CW_NONE;
        if (wr_commit) begin
            if (!wr_a0 && wr_data[ICW1_D4]) begin
                emit     = 1'b1;
                typ_n    = CW_ICW1;
                sngl_n   = wr_data[SNGL];
                ic4_n    = wr_data[IC4];
                rd_isr_n = RD_ISR_RST;
                state_n  = WAIT_ICW2;
            end else begin
                case (state)
                    WAIT_ICW2: if (wr_a0) begin
                        emit  = 1'b1;
                        typ_n = CW_ICW2;
                        if (!sngl)    state_n = WAIT_ICW3;
                        else if (ic4) state_n = WAIT_ICW4;
                        else          state_n = READY;
                    end
                    WAIT_ICW3: if (wr_a0) begin
                        emit    = 1'b1;
                        typ_n   = CW_ICW3;
                        state_n = ic4 ? WAIT_ICW4 : READY;
                    end
                    WAIT_ICW4: if (wr_a0) begin
                        emit    = 1'b1;
                        typ_n   = CW_ICW4;
                        state_n = READY;
                    end
                    READY: begin
                        emit  = 1'b1;
                        typ_n = wr_a0 ? CW_OCW1 : wr_data[OCW3_D3] ? CW_OCW3 : CW_OCW2;
                        if (!wr_a0 && wr_data[OCW3_D3] && wr_data[RR]) rd_isr_n = wr_data[RIS];
                    end
                    default: ;
                endcase
            end
        end
        read_sel_n = rd_req ? (rd_a0 ? RD_IMR : rd_code(rd_isr)) : RD_IDLE;
    end

    assign init_done = (state == READY);
endmodule

// File: tb/tb_pic_rw_sequencer.sv
// tb_pic_rw_sequencer: directed and randomized bus cycles checked against a queue-based model of the init sequence.
module tb_pic_rw_sequencer;
`ifdef PIC_INPUT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset, cs_n, rd_n, wr_n, a0;
    logic [7:0] data_in;
    logic       cw_valid, data_oe, init_done;
    logic [2:0] cw_type, read_sel;
    logic [7:0] cw_data;

    int checks = 0;
    int failures = 0;

    // Model: ICW1 seen, ICW types still owed, read target is ISR
    bit m_init;
    int m_q[$];
    bit m_isr;

    pic_rw_sequencer dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
        .data_in(data_in), .cw_valid(cw_valid), .cw_type(cw_type), .cw_data(cw_data),
        .read_sel(read_sel), .data_oe(data_oe), .init_done(init_done)
    );

    always #5 clk = ~clk;

    function automatic bit m_ready();
        return m_init && m_q.size() == 0;
    endfunction

    function automatic void m_reset();
        m_init = 0;
        m_q.delete();
        m_isr = 0;
    endfunction

    function automatic void model_write(input logic wa, input logic [7:0] wd, output bit ev, output int et);
        ev = 0;
        et = 7;
        if (!wa && wd[4]) begin
            m_init = 1;
            m_isr = 0;
            m_q.delete();
            m_q.push_back(1);
            if (!wd[1]) m_q.push_back(2);
            if (wd[0]) m_q.push_back(3);
            ev = 1;
            et = 0;
        end else if (!m_init) begin
            ev = 0;
        end else if (m_q.size() > 0) begin
            if (wa) begin
                ev = 1;
                et = m_q.pop_front();
            end
        end else if (wa) begin
            ev = 1;
            et = 4;
        end else if (wd[3]) begin
            ev = 1;
            et = 6;
            if (wd[1]) m_isr = wd[0];
        end else begin
            ev = 1;
            et = 5;
        end
    endfunction

    task automatic idle_bus();
        cs_n = 1; rd_n = 1; wr_n = 1; a0 = 0; data_in = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        repeat (LAT + 2) @(negedge clk);
        m_reset();
        checks++;
        if ({cw_valid, cw_type, cw_data, read_sel, data_oe, init_done} !== {1'b0, 3'd7, 8'h00, 3'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got v=%b t=%0d d=%h rs=%b oe=%b id=%b exp v=0 t=7 d=00 rs=000 oe=0 id=0",
                     cw_valid, cw_type, cw_data, read_sel, data_oe, init_done);
        end
        reset = 0;
        repeat (LAT + 1) @(negedge clk);
    endtask

    task automatic do_write(input logic wa, input logic [7:0] wd);
        bit ev;
        int et, hits, first;
        logic [2:0] gt;
        logic [7:0] gd;
        logic init_after;
        model_write(wa, wd, ev, et);
        hits = 0; first = -1; gt = 0; gd = 0; init_after = 0;
        @(negedge clk); cs_n = 0; wr_n = 0; a0 = wa; data_in = wd;
        @(negedge clk); wr_n = 1;
        @(negedge clk); cs_n = 1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (cw_valid === 1'b1) begin
                hits++;
                if (first < 0) begin first = i; gt = cw_type; gd = cw_data; end
            end
            if (first >= 0 && i == first + 1) init_after = init_done;
        end
        checks++;
        if (hits != (ev ? 1 : 0)) begin
            failures++;
            $display("FAIL strobe_count a0=%0d d=%h got=%0d exp=%0d", wa, wd, hits, ev ? 1 : 0);
        end
        if (ev) begin
            checks++;
            if (first != LAT) begin
                failures++;
                $display("FAIL strobe_latency a0=%0d d=%h got=%0d exp=%0d", wa, wd, first, LAT);
            end
            checks++;
            if (gt !== 3'(et) || gd !== wd) begin
                failures++;
                $display("FAIL cw_type_data a0=%0d d=%h got t=%0d d=%h exp t=%0d d=%h", wa, wd, gt, gd, et, wd);
            end
            checks++;
            if (init_after !== m_ready()) begin
                failures++;
                $display("FAIL init_after_strobe got=%b exp=%b", init_after, m_ready());
            end
        end
        checks++;
        if (init_done !== m_ready()) begin
            failures++;
            $display("FAIL init_done got=%b exp=%b", init_done, m_ready());
        end
    endtask

    task automatic do_read(input logic ra);
        logic [2:0] exp;
        exp = ra ? 3'b011 : (m_isr ? 3'b101 : 3'b001);
        @(negedge clk); cs_n = 0; rd_n = 0; a0 = ra;
        repeat (LAT + 1) @(negedge clk);
        checks++;
        if (read_sel !== exp || data_oe !== 1'b1) begin
            failures++;
            $display("FAIL read_active a0=%0d got rs=%b oe=%b exp rs=%b oe=1", ra, read_sel, data_oe, exp);
        end
        cs_n = 1; rd_n = 1;
        repeat (LAT + 2) @(negedge clk);
        checks++;
        if (read_sel !== 3'b000 || data_oe !== 1'b0) begin
            failures++;
            $display("FAIL read_release got rs=%b oe=%b exp rs=000 oe=0", read_sel, data_oe);
        end
    endtask

    task automatic test_reset();
        idle_bus();
        reset = 1;
        repeat (3) @(negedge clk);
        do_reset();
    endtask

    task automatic test_single_no_icw4();
        do_write(0, 8'h12);
        do_write(1, 8'h08);
    endtask

    task automatic test_cascade_icw4();
        do_reset();
        do_write(0, 8'h11);
        do_write(1, 8'h20);
        do_write(1, 8'h04);
        do_write(1, 8'h01);
    endtask

    task automatic test_ready_ocws();
        do_write(1, 8'hFB);
        do_write(0, 8'h20);
        do_write(0, 8'h0B);
        do_read(0);
        do_read(1);
    endtask

    task automatic test_reinit();
        do_write(0, 8'h11);
        do_write(1, 8'h20);
        do_write(0, 8'h13);
        do_read(0);
        do_write(0, 8'h05);
    endtask

    task automatic test_illegal();
        int hits;
        hits = 0;
        @(negedge clk); cs_n = 0; wr_n = 0; a0 = 1; data_in = 8'h55;
        @(negedge clk); rd_n = 0;
        @(negedge clk); rd_n = 1; wr_n = 1; cs_n = 1;
        for (int i = 0; i < 6; i++) begin
            if (cw_valid === 1'b1) hits++;
            if (read_sel !== 3'b000) hits++;
            @(negedge clk);
        end
        checks++;
        if (hits != 0) begin
            failures++;
            $display("FAIL illegal_rd_wr got events=%0d exp=0", hits);
        end
        hits = 0;
        @(negedge clk); cs_n = 0; wr_n = 0; a0 = 1; data_in = 8'h66;
        @(negedge clk); cs_n = 1;
        @(negedge clk); wr_n = 1;
        for (int i = 0; i < 6; i++) begin
            if (cw_valid === 1'b1) hits++;
            @(negedge clk);
        end
        checks++;
        if (hits != 0) begin
            failures++;
            $display("FAIL cs_early_release got strobes=%0d exp=0", hits);
        end
        do_reset();
        do_write(1, 8'hFB);
        do_write(0, 8'h0B);
    endtask

    task automatic test_back_to_back();
        bit e1, e2;
        int t1, t2;
        logic [2:0] ty[6];
        logic v[6];
        model_write(1, 8'hA5, e1, t1);
        model_write(0, 8'h08, e2, t2);
        @(negedge clk); cs_n = 0; wr_n = 0; a0 = 1; data_in = 8'hA5;
        @(negedge clk); wr_n = 1;
        @(negedge clk); v[0] = cw_valid; ty[0] = cw_type; wr_n = 0; a0 = 0; data_in = 8'h08;
        @(negedge clk); v[1] = cw_valid; ty[1] = cw_type; wr_n = 1;
        @(negedge clk); v[2] = cw_valid; ty[2] = cw_type; cs_n = 1;
        for (int i = 3; i < 6; i++) begin
            @(negedge clk); v[i] = cw_valid; ty[i] = cw_type;
        end
        checks++;
        if (v[LAT] !== 1'b1 || v[LAT + 1] !== 1'b0 || v[LAT + 2] !== 1'b1 || v[LAT + 3] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_strobes got %b%b%b%b exp 1010", v[LAT], v[LAT + 1], v[LAT + 2], v[LAT + 3]);
        end
        checks++;
        if (ty[LAT] !== 3'(t1) || ty[LAT + 2] !== 3'(t2)) begin
            failures++;
            $display("FAIL b2b_types got %0d,%0d exp %0d,%0d", ty[LAT], ty[LAT + 2], t1, t2);
        end
    endtask

    task automatic test_reset_mid();
        int hits;
        hits = 0;
        do_write(0, 8'h12);
        @(negedge clk); cs_n = 0; wr_n = 0; a0 = 1; data_in = 8'h08;
        @(negedge clk); reset = 1;
        @(negedge clk); wr_n = 1; cs_n = 1;
        repeat (LAT + 1) @(negedge clk);
        reset = 0;
        m_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cw_valid === 1'b1) hits++;
        end
        checks++;
        if (hits != 0 || init_done !== 1'b0 || cw_type !== 3'd7) begin
            failures++;
            $display("FAIL reset_mid got strobes=%0d id=%b t=%0d exp 0,0,7", hits, init_done, cw_type);
        end
        do_write(1, 8'h08);
    endtask

    task automatic test_random();
        int r;
        logic [7:0] d;
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            d = 8'($urandom);
            if (r < 2) do_read(1'($urandom));
            else if (r == 2) do_write(0, d | 8'h10);
            else do_write(1'($urandom), d);
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_single_no_icw4();
        test_cascade_icw4();
        test_ready_ocws();
        test_back_to_back();
        test_reinit();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
